// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: default sizes,
// dump FSM encoding and the byte-strobe merge helper.
package regfile_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 5;

    typedef enum logic {
        StIdle = 1'b0,
        StDump = 1'b1
    } dump_state_e;

    // One byte lane of a strobed write: take the new byte only when strobed.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       strb);
        return strb ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// Single combinational read port: range check, optional zero register and
// optional same-cycle forwarding of a strobed write.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned NUM_REGS = 2 ** ADDR_W,
    parameter bit          ZERO_R0  = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [DATA_W-1:0]   regs_i [NUM_REGS],
    input  logic                wr_ok_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned NumLanes = DATA_W / 8;

    always_comb begin
        rdata_o = '0;
        if ((32'(raddr_i) < NUM_REGS) && !(ZERO_R0 && (raddr_i == '0))) begin
            rdata_o = regs_i[raddr_i];
            // wr_ok_i already excludes out-of-range and zero-register writes
            if (BYPASS && wr_ok_i && (raddr_i == waddr_i)) begin
                for (int unsigned i = 0; i < NumLanes; i++) begin
                    rdata_o[8*i +: 8] = merge_byte(regs_i[raddr_i][8*i +: 8],
                                                   wdata_i[8*i +: 8], wstrb_i[i]);
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register bank with byte-strobed writes, N_RD combinational
// read ports and a handshaked sequential dump port for debug/trace.
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned NUM_REGS = 2 ** ADDR_W,
    parameter int unsigned N_RD     = 2,
    parameter bit          ZERO_R0  = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    wstrb,
    input  logic [N_RD*ADDR_W-1:0] raddr,
    output logic [N_RD*DATA_W-1:0] rdata,
    input  logic                   dump_start,
    output logic                   dump_busy,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [ADDR_W-1:0]      dump_addr,
    output logic [DATA_W-1:0]      dump_data,
    output logic                   dump_last
);

    localparam int unsigned NumLanes = DATA_W / 8;
    localparam int unsigned IdxW     = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = we && (32'(waddr) < NUM_REGS) && !(ZERO_R0 && (waddr == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            for (int unsigned i = 0; i < NumLanes; i++) begin
                regs_d[waddr][8*i +: 8] = merge_byte(regs_q[waddr][8*i +: 8],
                                                     wdata[8*i +: 8], wstrb[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_R0  (ZERO_R0),
            .BYPASS   (BYPASS)
        ) u_rd (
            .regs_i  (regs_q),
            .wr_ok_i (wr_ok),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .wstrb_i (wstrb),
            .raddr_i (raddr[k*ADDR_W +: ADDR_W]),
            .rdata_o (rdata[k*DATA_W +: DATA_W])
        );
    end

    dump_state_e       state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] dump_rd;
    logic              idx_last;

    // Extra index bit keeps the final compare wrap-free at full depth.
    assign idx_last = (idx_q == IdxW'(NUM_REGS - 1));

    // Dump beats show stored contents only, never the in-flight write.
    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_R0  (ZERO_R0),
        .BYPASS   (1'b0)
    ) u_dump_rd (
        .regs_i  (regs_q),
        .wr_ok_i (1'b0),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .raddr_i (idx_q[ADDR_W-1:0]),
        .rdata_o (dump_rd)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        case (state_q)
            StIdle: begin
                if (dump_start) begin
                    state_d = StDump;
                    idx_d   = '0;
                end
            end
            StDump: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                dump_last  = idx_last;
                dump_addr  = idx_q[ADDR_W-1:0];
                dump_data  = dump_rd;
                if (dump_ready) begin
                    if (idx_last) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (default config, and a 20-entry
// no-zero-register no-bypass config) driven by shared stimulus.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst, we, dump_start, dump_ready;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [9:0]  raddr;

    logic [63:0] rdata_v [2];
    logic        dbusy   [2];
    logic        dvalid  [2];
    logic        dlast   [2];
    logic [4:0]  daddr   [2];
    logic [31:0] ddata   [2];

    always #5 clk = ~clk;

    reg_file_param #(
        .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .N_RD(2), .ZERO_R0(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr(raddr), .rdata(rdata_v[0]), .dump_start(dump_start), .dump_busy(dbusy[0]),
        .dump_valid(dvalid[0]), .dump_ready(dump_ready), .dump_addr(daddr[0]),
        .dump_data(ddata[0]), .dump_last(dlast[0])
    );

    reg_file_param #(
        .DATA_W(32), .ADDR_W(5), .NUM_REGS(20), .N_RD(2), .ZERO_R0(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr(raddr), .rdata(rdata_v[1]), .dump_start(dump_start), .dump_busy(dbusy[1]),
        .dump_valid(dvalid[1]), .dump_ready(dump_ready), .dump_addr(daddr[1]),
        .dump_data(ddata[1]), .dump_last(dlast[1])
    );

    // Reference model: plain register arrays plus a "dumping / next index" pair.
    logic [31:0] mdl [2][32];
    bit          m_dump [2];
    int          m_idx  [2];
    int          checks = 0;
    int          errors = 0;
    int          beats_dut = 0;
    bit          chk_en = 1'b0;

    function automatic int nregs(input int n);
        return (n == 0) ? 32 : 20;
    endfunction

    function automatic bit has_zero(input int n);
        return n == 0;
    endfunction

    function automatic bit has_byp(input int n);
        return n == 0;
    endfunction

    function automatic bit legal(input int n);
        return we && (int'(waddr) < nregs(n)) && !(has_zero(n) && waddr == 5'd0);
    endfunction

    function automatic logic [31:0] smask(input logic [3:0] s);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic logic [31:0] exp_read(input int n, input logic [4:0] a);
        logic [31:0] m;
        if (int'(a) >= nregs(n) || (has_zero(n) && a == 5'd0)) return 32'h0;
        if (has_byp(n) && legal(n) && a == waddr) begin
            m = smask(wstrb);
            return (mdl[n][a] & ~m) | (wdata & m);
        end
        return mdl[n][a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check everything against the model mid-cycle, clock once, advance the model.
    task automatic cycle();
        logic [31:0] ed;
        #1;
        if (chk_en) begin
            for (int n = 0; n < 2; n++) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("rd i%0d p%0d a%0d", n, k, raddr[k*5 +: 5]),
                        rdata_v[n][k*32 +: 32], exp_read(n, raddr[k*5 +: 5]));
                end
                ed = m_dump[n] ? mdl[n][m_idx[n]] : 32'h0;
                chk($sformatf("dump_valid i%0d", n), 32'(dvalid[n]), 32'(m_dump[n]));
                chk($sformatf("dump_busy i%0d", n), 32'(dbusy[n]), 32'(m_dump[n]));
                chk($sformatf("dump_addr i%0d", n), 32'(daddr[n]),
                    m_dump[n] ? 32'(m_idx[n]) : 32'h0);
                chk($sformatf("dump_data i%0d", n), ddata[n], ed);
                chk($sformatf("dump_last i%0d", n), 32'(dlast[n]),
                    32'(m_dump[n] && m_idx[n] == nregs(n) - 1));
            end
            if (dvalid[0] === 1'b1 && dump_ready) beats_dut++;
        end
        @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) mdl[n][i] = 32'h0;
                m_dump[n] = 1'b0;
                m_idx[n]  = 0;
            end else begin
                if (legal(n)) mdl[n][waddr] = (mdl[n][waddr] & ~smask(wstrb)) |
                                              (wdata & smask(wstrb));
                if (m_dump[n]) begin
                    if (dump_ready) begin
                        m_idx[n]++;
                        if (m_idx[n] == nregs(n)) m_dump[n] = 1'b0;
                    end
                end else if (dump_start) begin
                    m_dump[n] = 1'b1;
                    m_idx[n]  = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1'b1; waddr = a; wdata = d; wstrb = s;
        cycle();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset clears written contents
        write(5'd5, 32'hDEADBEEF, 4'hF);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        raddr = {5'd14, 5'd5};
        #1;
        chk("reset r5", rdata_v[0][31:0], 32'h0);
        chk("reset r14", rdata_v[0][63:32], 32'h0);
        chk("reset dump_valid", 32'(dvalid[0]), 32'h0);
        cycle();

        // Zero register only on instance a
        write(5'd0, 32'hFFFFFFFF, 4'hF);
        raddr = {5'd1, 5'd0};
        #1;
        chk("r0 zero", rdata_v[0][31:0], 32'h0);
        chk("r0 plain", rdata_v[1][31:0], 32'hFFFFFFFF);
        cycle();

        // Byte strobes
        write(5'd3, 32'h11223344, 4'hF);
        write(5'd3, 32'hAABBCCDD, 4'b0101);
        write(5'd3, 32'h99999999, 4'h0);
        raddr = {5'd0, 5'd3};
        #1;
        chk("strobe a", rdata_v[0][31:0], 32'h11BB33DD);
        chk("strobe b", rdata_v[1][31:0], 32'h11BB33DD);
        cycle();

        // Same-cycle forwarding on a only
        raddr = {5'd0, 5'd7};
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; wstrb = 4'hF;
        #1;
        chk("bypass a", rdata_v[0][31:0], 32'h12345678);
        chk("bypass b", rdata_v[1][31:0], 32'h0);
        cycle();
        we = 1'b0;
        #1;
        chk("after write a", rdata_v[0][31:0], 32'h12345678);
        chk("after write b", rdata_v[1][31:0], 32'h12345678);
        cycle();

        // Dump with backpressure and an ignored second start
        for (int i = 0; i < 32; i++) write(5'(i), 32'(i) * 32'h101, 4'hF);
        beats_dut = 0;
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        for (int c = 0; c < 200 && (m_dump[0] || m_dump[1]); c++) begin
            dump_ready = c[0];
            dump_start = (c == 20);
            raddr = 10'($urandom);
            cycle();
        end
        dump_ready = 1'b0;
        dump_start = 1'b0;
        #1;
        chk("dump beats", 32'(beats_dut), 32'd32);
        chk("dump busy end", 32'(dbusy[0]), 32'h0);
        cycle();

        // Reset during beat 10, then restart from index 0
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        #1;
        chk("beat10 addr", 32'(daddr[0]), 32'd10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        dump_ready = 1'b0;
        #1;
        chk("rst dump idle", 32'(dvalid[0]), 32'h0);
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        #1;
        chk("restart valid", 32'(dvalid[0]), 32'h1);
        chk("restart addr", 32'(daddr[0]), 32'h0);
        chk("restart data", ddata[0], 32'h0);
        cycle();

        // Random traffic, including writes and reads during dumps
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(63) == 0);
            we         = 1'($urandom);
            waddr      = 5'($urandom);
            wdata      = $urandom;
            wstrb      = 4'($urandom);
            raddr      = 10'($urandom);
            if ($urandom_range(1) == 0) raddr[4:0] = waddr;
            dump_start = ($urandom_range(15) == 0);
            dump_ready = 1'($urandom);
            cycle();
        end
        rst = 1'b0; we = 1'b0; dump_start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
